// File: rtl/smg_pkg.sv
// Shared types and constants for the seven-segment scan/page controller.
package smg_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [1:0] PAGE_FX   = 2'd0;
  localparam logic [1:0] PAGE_TM   = 2'd1;
  localparam logic [1:0] PAGE_ZK   = 2'd2;
  localparam logic [1:0] PAGE_LAST = PAGE_ZK;

  localparam int NUM_DIGITS = 8;

  function automatic logic [31:0] page_word(input logic [1:0]  page,
                                            input logic [31:0] fx,
                                            input logic [31:0] tm,
                                            input logic [31:0] zk);
    case (page)
      PAGE_TM: return tm;
      PAGE_ZK: return zk;
      default: return fx;
    endcase
  endfunction

  function automatic logic [1:0] next_page(input logic [1:0] page);
    return (page == PAGE_LAST) ? PAGE_FX : page + 2'd1;
  endfunction

endpackage

// File: rtl/smg_key_cond.sv
// Page-key conditioner: 2-FF synchroniser, optional stability filter (SMG_DEBOUNCE_EN), rising-edge press pulse.
// press_o rises 3 cycles after the key, or DEBOUNCE_TICKS+3 cycles with the filter enabled.
module smg_key_cond #(
  parameter int DEBOUNCE_TICKS = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic lvl;
  logic lvl_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync1_q    <= key_i;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
    end
  end

`ifdef SMG_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [CW-1:0] cnt_q;
  logic          lvl_q;

  // The level flips only after DEBOUNCE_TICKS consecutive disagreeing samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (sync2_q == lvl_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      lvl_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign lvl = lvl_q;
`else
  localparam int unused_debounce_ticks = DEBOUNCE_TICKS;
  assign lvl = sync2_q;
`endif

  assign press_o = lvl & ~lvl_prev_q;

endmodule

// File: rtl/smg_scan_ctrl.sv
// 8-digit scan/page controller: LOAD/SCAN/GAP digit sequencing, frame-coherent snapshot, key/auto page stepping.
// All outputs registered; frame = 1 + 8*(DIGIT_TICKS+BLANK_TICKS) cycles. Optional key filter: SMG_DEBOUNCE_EN.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int DIGIT_TICKS    = 50000,
  parameter int BLANK_TICKS    = 500,
  parameter int PAGE_FRAMES    = 200,
  parameter int DEBOUNCE_TICKS = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        key_page_i,
  input  logic        auto_en_i,
  input  logic [31:0] data_fx_i,
  input  logic [31:0] data_tm_i,
  input  logic [31:0] data_zk_i,
  output logic [2:0]  bit_sel_o,
  output logic [1:0]  d_m_o,
  output logic [31:0] disp_data_o,
  output logic        blank_o,
  output logic        frame_done_o
);

  localparam int TICK_MAX = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int TW       = $clog2(TICK_MAX + 1);
  localparam int FW       = $clog2(PAGE_FRAMES + 1);

  localparam logic [TW-1:0] DIG_LAST   = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(BLANK_TICKS - 1);
  localparam logic [FW-1:0] DWELL_FULL = FW'(PAGE_FRAMES);
  localparam logic [2:0]    BIT_LAST   = 3'(NUM_DIGITS - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [FW-1:0] dwell_q, dwell_d;
  logic          pend_q, pend_d;
  logic [2:0]    bit_sel_q, bit_sel_d;
  logic [1:0]    d_m_q, d_m_d;
  logic [31:0]   disp_q, disp_d;
  logic          blank_q, blank_d;
  logic          frame_done_q, frame_done_d;
  logic          boundary;
  logic          advance;
  logic          press;

  smg_key_cond #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_key_cond (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .key_i  (key_page_i),
    .press_o(press)
  );

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_sel_d = bit_sel_q;
    d_m_d     = d_m_q;
    disp_d    = disp_q;
    dwell_d   = auto_en_i ? dwell_q : '0;
    pend_d    = pend_q | press;
    boundary  = 1'b0;
    advance   = 1'b0;

    case (state_q)
      LOAD: begin
        disp_d    = page_word(d_m_q, data_fx_i, data_tm_i, data_zk_i);
        bit_sel_d = '0;
        tick_d    = '0;
        state_d   = SCAN;
      end
      SCAN: begin
        if (tick_q == DIG_LAST) begin
          tick_d = '0;
          if (BLANK_TICKS != 0)       state_d   = GAP;
          else if (bit_sel_q != BIT_LAST) bit_sel_d = bit_sel_q + 3'd1;
          else                        boundary  = 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      GAP: begin
        if (tick_q == GAP_LAST) begin
          tick_d = '0;
          if (bit_sel_q != BIT_LAST) begin
            bit_sel_d = bit_sel_q + 3'd1;
            state_d   = SCAN;
          end else begin
            boundary = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase

    // A press landing on the boundary cycle survives into the next frame's pending flag.
    if (boundary) begin
      state_d   = LOAD;
      bit_sel_d = '0;
      advance   = pend_q | (auto_en_i & (dwell_q == DWELL_FULL));
      if (advance) begin
        d_m_d   = next_page(d_m_q);
        dwell_d = '0;
        pend_d  = press;
      end else if (auto_en_i && dwell_q != DWELL_FULL) begin
        dwell_d = dwell_q + 1'b1;
      end
    end

    blank_d = (state_d != SCAN);
    if (BLANK_TICKS != 0)
      frame_done_d = (state_d == GAP) && (bit_sel_d == BIT_LAST) && (tick_d == GAP_LAST);
    else
      frame_done_d = (state_d == SCAN) && (bit_sel_d == BIT_LAST) && (tick_d == DIG_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= LOAD;
      tick_q       <= '0;
      dwell_q      <= '0;
      pend_q       <= 1'b0;
      bit_sel_q    <= '0;
      d_m_q        <= PAGE_FX;
      disp_q       <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      dwell_q      <= dwell_d;
      pend_q       <= pend_d;
      bit_sel_q    <= bit_sel_d;
      d_m_q        <= d_m_d;
      disp_q       <= disp_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bit_sel_o    = bit_sel_q;
  assign d_m_o        = d_m_q;
  assign disp_data_o  = disp_q;
  assign blank_o      = blank_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Randomised scoreboard bench for smg_scan_ctrl against a frame-position reference model.
module tb_smg_scan_ctrl;

  localparam int DT    = 4;
  localparam int BT    = 2;
  localparam int PF    = 3;
  localparam int DB    = 8;
  localparam int SLOT  = DT + BT;
  localparam int FRAME = 1 + 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key = 1'b0;
  logic        auto_en = 1'b0;
  logic [31:0] dfx = 32'h1234_5678;
  logic [31:0] dtm = 32'h0001_2345;
  logic [31:0] dzk = 32'h8765_4321;
  logic [2:0]  bit_sel;
  logic [1:0]  d_m;
  logic [31:0] disp;
  logic        blank;
  logic        fdone;

  always #5 clk = ~clk;

  smg_scan_ctrl #(
    .DIGIT_TICKS   (DT),
    .BLANK_TICKS   (BT),
    .PAGE_FRAMES   (PF),
    .DEBOUNCE_TICKS(DB)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_page_i  (key),
    .auto_en_i   (auto_en),
    .data_fx_i   (dfx),
    .data_tm_i   (dtm),
    .data_zk_i   (dzk),
    .bit_sel_o   (bit_sel),
    .d_m_o       (d_m),
    .disp_data_o (disp),
    .blank_o     (blank),
    .frame_done_o(fdone)
  );

  typedef struct packed {
    logic [2:0]  bs;
    logic [1:0]  dm;
    logic [31:0] dd;
    logic        bl;
    logic        fd;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: position within the frame, current page, snapshot, pending press, dwell.
  int          m_pos   = 0;
  int          m_dm    = 0;
  logic [31:0] m_disp  = '0;
  bit          m_pend  = 1'b0;
  int          m_dwell = 0;
  bit          k1 = 1'b0, k2 = 1'b0, k3 = 1'b0;
`ifdef SMG_DEBOUNCE_EN
  bit ml1 = 1'b0, ml2 = 1'b0;
  int mrun = 0;
`endif

  always @(posedge clk) begin
    exp_t e;
    bit   press;
    bit   adv;
    int   p;
    if (rst) begin
      m_pos = 0; m_dm = 0; m_disp = '0; m_pend = 1'b0; m_dwell = 0;
      k1 = 1'b0; k2 = 1'b0; k3 = 1'b0;
`ifdef SMG_DEBOUNCE_EN
      ml1 = 1'b0; ml2 = 1'b0; mrun = 0;
`endif
    end else begin
`ifdef SMG_DEBOUNCE_EN
      press = ml1 & ~ml2;
      ml2 = ml1;
      if (k2 != ml1) begin
        mrun++;
        if (mrun == DB) begin
          ml1  = k2;
          mrun = 0;
        end
      end else begin
        mrun = 0;
      end
`else
      press = k2 & ~k3;
`endif
      if (m_pos == 0)
        m_disp = (m_dm == 0) ? dfx : (m_dm == 1) ? dtm : dzk;
      if (m_pos == FRAME - 1) begin
        adv = m_pend || (auto_en && m_dwell >= PF);
        if (adv) begin
          m_dm    = (m_dm + 1) % 3;
          m_dwell = 0;
        end else begin
          m_dwell = auto_en ? ((m_dwell < PF) ? m_dwell + 1 : PF) : 0;
        end
        m_pend = press;
      end else begin
        if (!auto_en) m_dwell = 0;
        m_pend = m_pend | press;
      end
      m_pos = (m_pos + 1) % FRAME;
      k3 = k2; k2 = k1; k1 = key;
    end
    if (m_pos == 0) begin
      e.bs = 3'd0;
      e.bl = 1'b1;
    end else begin
      p    = m_pos - 1;
      e.bs = 3'(p / SLOT);
      e.bl = (p % SLOT) >= DT;
    end
    e.fd = (m_pos == FRAME - 1);
    e.dm = 2'(m_dm);
    e.dd = m_disp;
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {bit_sel, d_m, disp, blank, fdone};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got bit_sel=%0d d_m=%0d disp_data=%h blank=%b frame_done=%b, expected bit_sel=%0d d_m=%0d disp_data=%h blank=%b frame_done=%b",
                 $time, a.bs, a.dm, a.dd, a.bl, a.fd, e.bs, e.dm, e.dd, e.bl, e.fd);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for a model position, optionally a page and a full dwell counter.
  task automatic wait_for(input int want_dm, input int want_pos, input bit need_dwell,
                          input int budget, input string tag);
    int n = 0;
    while (!((want_dm < 0 || m_dm == want_dm) && m_pos == want_pos &&
             (!need_dwell || m_dwell == PF)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: condition not reached within %0d cycles", tag, budget);
    end
  endtask

  task automatic pulse_key(input int width);
    key = 1'b1;
    cyc(width);
    key = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    rst = 1'b0;

    // Free run; data_fx changes while digit 3 is lit and must not reach the display until the next LOAD.
    wait_for(-1, 1 + 3 * SLOT + 1, 1'b0, 2 * FRAME, "wait_digit3");
    dfx = 32'h9ABC_DEF0;
    cyc(2 * FRAME);

    // Auto rotation through all pages and back to page 0.
    auto_en = 1'b1;
    cyc(13 * FRAME);
    auto_en = 1'b0;
    cyc(FRAME);

    // Deterministic long and short key pulses.
    pulse_key(12);
    cyc(2 * FRAME);
    pulse_key(5);
    cyc(2 * FRAME);

    // Random key pulses and data churn.
    for (int i = 0; i < 40; i++) begin
      cyc($urandom_range(5, 60));
      if ($urandom_range(0, 2) == 0) dfx = $urandom;
      if ($urandom_range(0, 2) == 0) dtm = $urandom;
      if ($urandom_range(0, 2) == 0) dzk = $urandom;
      pulse_key($urandom_range(1, 14));
    end
    cyc(2 * FRAME);

    // Key pending at the same boundary where the auto dwell expires.
    auto_en = 1'b1;
    wait_for(-1, 5, 1'b1, 8 * FRAME, "wait_dwell_full");
    pulse_key(12);
    cyc(6 * FRAME);

    // Reset during digit 5 of page 2, then resume.
    wait_for(2, 1 + 5 * SLOT + 1, 1'b0, 20 * FRAME, "wait_page2_digit5");
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    auto_en = 1'b0;
    cyc(2 * FRAME);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/smg_scan_ctrl.md
# smg_scan_ctrl

Scan and page controller for the 8-digit seven-segment display of the frequency-measurement design. It generates the digit select and blanking for the segment decoder, and steps the display page: frequency, period/time, or duty. Page changes come from a push-button or an auto-rotate timer. At every frame start it takes a frame-coherent snapshot of the selected 32-bit BCD word, so a digit never tears mid-frame.

## Interface
- DIGIT_TICKS, 50000: clock cycles each digit is lit (≥1).
- BLANK_TICKS, 500: all-off cycles after each digit (0 = no blanking).
- PAGE_FRAMES, 200: frames per page in auto-rotate (≥1).
- DEBOUNCE_TICKS, 1000000: stable cycles needed to accept a key level (used only with SMG_DEBOUNCE_EN).
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- key_page  in  1  raw page button, asynchronous, active-high.
- auto_en  in  1  enables auto page rotation.
- data_fx  in  32  8-digit BCD, page 0.
- data_tm  in  32  8-digit BCD, page 1.
- data_zk  in  32  8-digit BCD, page 2.
- bit_sel  out  3  current digit index; 0 = most significant nibble [31:28].
- d_m  out  2  current page: 0, 1 or 2. The value 3 is never driven.
- disp_data  out  32  snapshot of the selected page word.
- blank  out  1  1 = all digits off.
- frame_done  out  1  one-cycle pulse at the end of each frame.

## Operation
- FSM states: LOAD, SCAN, GAP.
  - LOAD: one cycle, blank=1. disp_data ← word selected by the current d_m. bit_sel ← 0. Go to SCAN.
  - SCAN: blank=0 for DIGIT_TICKS cycles. Then go to GAP, or if BLANK_TICKS=0 treat GAP as zero-length.
  - GAP: blank=1 for BLANK_TICKS cycles, with bit_sel held.
    - If bit_sel<7: bit_sel+1, go to SCAN.
    - If bit_sel=7: pulse frame_done on the final GAP cycle (on the final SCAN cycle when BLANK_TICKS=0), apply the page update, go to LOAD.
- Page update is evaluated only at a frame boundary:
  - Advance if a key press is pending, or if auto_en=1 and the dwell counter has reached PAGE_FRAMES.
  - Advance sequence: 0→1→2→0.
  - An advance clears the pending key flag and resets the dwell counter to 0.
  - If there is no advance, the dwell counter increments, saturating at PAGE_FRAMES.
  - Key and auto both due on the same boundary: exactly one advance.
- Key press handling:
  - Each press is the rising edge of the conditioned key level. It sets the pending flag; the flag holds one press (multiple presses within a frame = one advance).
  - A press occurring in the same cycle as the boundary update is applied at the next boundary.
- When auto_en=0, the dwell counter holds at 0.
- Counters: tick counter width is $clog2(max(DIGIT_TICKS,BLANK_TICKS)+1); dwell counter width is $clog2(PAGE_FRAMES+1).

## Timing
- Reset values: bit_sel=0, d_m=0, disp_data=0, blank=1, frame_done=0. The FSM is in LOAD, all counters are 0 and the pending flag is clear.
- First cycle after rst deasserts: LOAD. First lit digit appears on the following cycle.
- Frame period: 1 + 8·(DIGIT_TICKS+BLANK_TICKS) cycles.
- d_m changes in the LOAD cycle, in the same cycle as the disp_data load. disp_data is stable for the entire frame.
- Outputs are registered. No combinational path from any input to any output.
- rst asserted mid-frame: all outputs return to reset values on the next edge, and any pending press is discarded.

## Configuration
- SMG_DEBOUNCE_EN defined:
  - key_page passes through a 2-FF synchronizer.
  - The conditioned level changes only after the synchronized input has been stable for DEBOUNCE_TICKS consecutive cycles.
  - Press = rising edge of the conditioned level.
- SMG_DEBOUNCE_EN undefined:
  - 2-FF synchronizer plus rising-edge detect only, no stability filter.
  - DEBOUNCE_TICKS is ignored.
- Press-to-pending latency: 3 cycles without the macro; DEBOUNCE_TICKS+3 with it.

## Structure
- Shared package smg_pkg holds:
  - the FSM state enum (LOAD, SCAN, GAP);
  - page constants PAGE_FX=0, PAGE_TM=1, PAGE_ZK=2 and PAGE_LAST=2;
  - NUM_DIGITS=8.
- One sub-module, smg_key_cond (synchronizer, optional debounce, edge detect), producing a one-cycle press pulse. Its debounce logic is guarded by SMG_DEBOUNCE_EN.

## Test plan
Common parameters: DIGIT_TICKS=4, BLANK_TICKS=2, PAGE_FRAMES=3, DEBOUNCE_TICKS=8.
- Free run, auto_en=0 → bit_sel steps 0..7.
  - Each digit: 4 cycles blank=0, then 2 cycles blank=1.
  - frame_done pulses every 49 cycles.
  - d_m stays 0.
- Change data_fx from 0x12345678 to 0x9ABCDEF0 during digit 3 → disp_data holds 0x12345678 until the next LOAD, then shows 0x9ABCDEF0.
- auto_en=1 → d_m sequence is 0,1,2,0, each page lasting 4 frames (the dwell counter reaches 3, then advances at the next boundary).
- With SMG_DEBOUNCE_EN:
  - key held high 12 cycles → exactly one d_m advance, at the next frame boundary.
  - 5-cycle pulse → no advance.
- Key press pending and auto dwell expiring at the same boundary → d_m advances by one only, and the dwell counter restarts from 0.
- rst asserted during digit 5, page 2 → next cycle bit_sel=0, d_m=0, blank=1, disp_data=0, frame_done=0. Normal scanning resumes with LOAD after release.
